// File: rtl/ram_arbiter.sv
// Arbitrates the single-port block RAM between the CPU (default owner) and a host port.
// Host grants stall the CPU, are bounded to MAX_BURST accesses, and are followed by a CPU slice.
module ram_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 6,
    parameter int unsigned DATA_WIDTH    = 10,
    parameter int unsigned MAX_BURST     = 8,
    parameter int unsigned CPU_SLICE     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    input  logic                     cpu_we,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_hold,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [ADDRESS_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0]    host_wdata,
    output logic                     host_ack,
    output logic                     host_rvalid,
    output logic [DATA_WIDTH-1:0]    host_rdata,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    output logic                     ram_we,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic                     owner
);

    localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
    localparam int unsigned SliceW = (CPU_SLICE > 0) ? $clog2(CPU_SLICE + 1) : 1;
    localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);
    localparam logic [SliceW-1:0] SliceLoad = SliceW'(CPU_SLICE);

    typedef enum logic [1:0] {StCpuOwn, StDrain, StHost, StReturn} state_e;

    state_e                  state_q, state_d;
    logic [BurstW-1:0]       burst_cnt_q, burst_cnt_d;
    logic [SliceW-1:0]       slice_cnt_q, slice_cnt_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                    host_accept;

    assign host_accept = (state_q == StHost) && host_req;

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        slice_cnt_d = slice_cnt_q;
        rvalid_d    = host_accept && !host_we;
        cpu_rdata_d = cpu_rdata_q;
        unique case (state_q)
            StCpuOwn: begin
                cpu_rdata_d = ram_rdata;
                if (slice_cnt_q != '0) begin
                    slice_cnt_d = slice_cnt_q - SliceW'(1);
                end
                // The slice expires on the edge where the counter reaches zero.
                if (host_req && (slice_cnt_q <= SliceW'(1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                cpu_rdata_d = ram_rdata;
                state_d     = StHost;
            end
            StHost: begin
                if (host_accept) begin
                    burst_cnt_d = burst_cnt_q + BurstW'(1);
                    if (burst_cnt_q == BurstLast) begin
                        state_d = StReturn;
                    end
                end else begin
                    state_d = StReturn;
                end
            end
            StReturn: begin
                burst_cnt_d = '0;
                slice_cnt_d = SliceLoad;
                state_d     = StCpuOwn;
            end
            default: state_d = StCpuOwn;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StCpuOwn;
            burst_cnt_q <= '0;
            slice_cnt_q <= '0;
            rvalid_q    <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            slice_cnt_q <= slice_cnt_d;
            rvalid_q    <= rvalid_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        cpu_rdata = cpu_rdata_q;
        unique case (state_q)
            StCpuOwn: begin
                ram_we    = cpu_we;
                cpu_rdata = ram_rdata;
            end
            StDrain: begin
                cpu_rdata = ram_rdata;
            end
            StHost: begin
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
                ram_we    = host_accept && host_we;
            end
            StReturn: begin
                ram_we = 1'b0;
            end
            default: ram_we = 1'b0;
        endcase
    end

    assign cpu_hold    = (state_q != StCpuOwn);
    assign owner       = (state_q == StHost);
    assign host_ack    = host_accept;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rvalid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed cycle table, directed corner sequences, then random traffic
// checked against a transaction-level memory model and ownership/fairness rules.
module tb_ram_arbiter;

    localparam int unsigned MaxBurst = 8;
    localparam int unsigned CpuSlice = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] cpu_addr;
    logic [9:0] cpu_wdata;
    logic       cpu_we;
    logic [9:0] cpu_rdata;
    logic       cpu_hold;
    logic       host_req;
    logic       host_we;
    logic [5:0] host_addr;
    logic [9:0] host_wdata;
    logic       host_ack;
    logic       host_rvalid;
    logic [9:0] host_rdata;
    logic [5:0] ram_addr;
    logic [9:0] ram_wdata;
    logic       ram_we;
    logic [9:0] ram_rdata = '0;
    logic       owner;

    ram_arbiter #(
        .ADDRESS_WIDTH(6),
        .DATA_WIDTH   (10),
        .MAX_BURST    (MaxBurst),
        .CPU_SLICE    (CpuSlice)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_rdata  (cpu_rdata),
        .cpu_hold   (cpu_hold),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    // Block RAM: registered read, old data returned on a same-address write.
    logic [9:0] mem [64];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    logic [9:0] ref_mem [64];
    logic [9:0] rd_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst, hreq, hwe;
        logic [5:0] haddr;
        logic [9:0] hwd;
        logic       cwe;
        logic [5:0] caddr;
        logic [9:0] cwd;
        logic       e_hold, e_ack, e_owner, e_rv;
        logic [9:0] e_hrd;
        logic       chk_crd;
        logic [9:0] e_crd;
    } vec_t;

    vec_t tbl [$];

    task automatic row(input int r, hq, hw, ha, hd, cw, ca, cd,
                       input int eh, ea, eo, er, ehr, cc, ec);
        vec_t v;
        v.rst = (r != 0);   v.hreq = (hq != 0);  v.hwe = (hw != 0);
        v.haddr = 6'(ha);   v.hwd = 10'(hd);
        v.cwe = (cw != 0);  v.caddr = 6'(ca);    v.cwd = 10'(cd);
        v.e_hold = (eh != 0); v.e_ack = (ea != 0); v.e_owner = (eo != 0); v.e_rv = (er != 0);
        v.e_hrd = 10'(ehr); v.chk_crd = (cc != 0); v.e_crd = 10'(ec);
        tbl.push_back(v);
    endtask

    task automatic compare_mem(input string name);
        for (int a = 0; a < 64; a++) chk(name, mem[a], ref_mem[a]);
    endtask

    int  acks, run, gap, groups, wait_cnt, grant_acks;
    logic seen_fall, have_grant, hold_prev, ack_prev, prev_rd, exp_crd_v, exp_we;
    logic [9:0] exp_crd;

    initial begin
        for (int a = 0; a < 64; a++) begin
            mem[a]     = '0;
            ref_mem[a] = '0;
        end
        rst = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // Reset held with a pending host request.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("reset_hold", cpu_hold, 0);
            chk("reset_ack", host_ack, 0);
            chk("reset_owner", owner, 0);
            chk("reset_rvalid", host_rvalid, 0);
            chk("reset_hrdata", host_rdata, 0);
        end

        // rst hreq hwe haddr hwd | cwe caddr cwd | hold ack owner rvalid hrdata | chk crd
        row(1, 0, 0, 0, 0,    1, 52, 15,  0, 0, 0, 0, 0,   0, 0);
        row(1, 0, 0, 0, 0,    0, 52, 0,   0, 0, 0, 0, 0,   0, 0);
        row(1, 0, 0, 0, 0,    0, 52, 0,   0, 0, 0, 0, 0,   1, 15);
        row(1, 0, 0, 0, 0,    1, 52, 50,  0, 0, 0, 0, 0,   1, 15);
        row(1, 0, 0, 0, 0,    0, 52, 0,   0, 0, 0, 0, 0,   0, 0);
        row(1, 1, 1, 0, 0,    0, 52, 0,   0, 0, 0, 0, 0,   1, 50);
        row(1, 1, 1, 0, 0,    0, 52, 0,   1, 0, 0, 0, 0,   1, 50);
        for (int i = 0; i < 8; i++) row(1, 1, 1, i, i, 0, 52, 0, 1, 1, 1, 0, 0, 1, 50);
        row(1, 0, 0, 0, 0,    0, 52, 0,   1, 0, 0, 0, 0,   1, 50);
        row(1, 1, 0, 52, 0,   0, 3, 0,    0, 0, 0, 0, 0,   1, 50);
        for (int i = 0; i < 3; i++) row(1, 1, 0, 52, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 3);
        row(1, 1, 0, 52, 0,   0, 3, 0,    1, 0, 0, 0, 0,   1, 3);
        row(1, 1, 0, 52, 0,   0, 3, 0,    1, 1, 1, 0, 0,   1, 3);
        row(1, 0, 0, 0, 0,    0, 3, 0,    1, 0, 1, 1, 50,  1, 3);
        row(1, 0, 0, 0, 0,    0, 3, 0,    1, 0, 0, 0, 0,   1, 3);
        for (int i = 0; i < 3; i++) row(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 3);
        row(1, 1, 1, 9, 999,  0, 3, 0,    0, 0, 0, 0, 0,   1, 3);
        row(1, 0, 0, 0, 0,    0, 3, 0,    1, 0, 0, 0, 0,   1, 3);
        row(1, 0, 0, 0, 0,    0, 3, 0,    1, 0, 1, 0, 0,   1, 3);
        row(1, 0, 0, 0, 0,    0, 3, 0,    1, 0, 0, 0, 0,   1, 3);
        row(1, 0, 0, 0, 0,    0, 3, 0,    0, 0, 0, 0, 0,   1, 3);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; host_req = tbl[i].hreq; host_we = tbl[i].hwe;
            host_addr = tbl[i].haddr; host_wdata = tbl[i].hwd;
            cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
            #1;
            chk($sformatf("vec%0d_hold", i), cpu_hold, tbl[i].e_hold);
            chk($sformatf("vec%0d_ack", i), host_ack, tbl[i].e_ack);
            chk($sformatf("vec%0d_owner", i), owner, tbl[i].e_owner);
            chk($sformatf("vec%0d_rvalid", i), host_rvalid, tbl[i].e_rv);
            chk($sformatf("vec%0d_hrdata", i), host_rdata, tbl[i].e_hrd);
            if (tbl[i].chk_crd) chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
        end

        for (int a = 0; a < 8; a++) ref_mem[a] = 10'(a);
        ref_mem[52] = 10'd50;
        compare_mem("mem_after_table");

        // Reset lands on the third accepted host read.
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'd5; cpu_we = 1'b0; cpu_addr = 6'd3;
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (host_ack) acks++;
            if (acks == 3) begin
                rst = 1'b0;
                break;
            end
        end
        chk("reads_before_reset", acks, 3);
        @(negedge clk); #1;
        chk("midreset_hold", cpu_hold, 0);
        chk("midreset_owner", owner, 0);
        chk("midreset_ack", host_ack, 0);
        chk("midreset_rvalid", host_rvalid, 0);
        chk("midreset_hrdata", host_rdata, 0);
        rst = 1'b1; host_req = 1'b0;
        compare_mem("mem_after_midreset");

        // Continuous host reads: fixed-size groups separated by a full CPU slice.
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'd7;
        run = 0; gap = 0; groups = 0; seen_fall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (host_ack) run++;
            else if (run != 0) begin
                chk("burst_group_len", run, MaxBurst);
                groups++;
                run = 0;
            end
            if (!cpu_hold) begin
                chk("no_ack_in_cpu_slice", host_ack, 0);
                gap++;
            end else begin
                if (seen_fall && gap != 0) chk("cpu_slice_len", gap, CpuSlice);
                gap = 0;
                seen_fall = 1'b1;
            end
        end
        chk("burst_groups_seen", groups >= 2, 1);
        host_req = 1'b0;
        repeat (20) @(negedge clk);

        // Random traffic against the transaction-level model.
        hold_prev = 1'b0; ack_prev = 1'b0; prev_rd = 1'b0; exp_crd_v = 1'b0; exp_crd = '0;
        have_grant = 1'b0; gap = 0; wait_cnt = 0; grant_acks = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (!host_req || ack_prev) begin
                host_req   = ($urandom_range(0, 2) != 0);
                host_we    = $urandom_range(0, 1) != 0;
                host_addr  = 6'($urandom_range(0, 63));
                host_wdata = 10'($urandom_range(0, 1023));
            end
            if (!cpu_hold) begin
                cpu_we    = $urandom_range(0, 1) != 0;
                cpu_addr  = 6'($urandom_range(0, 63));
                cpu_wdata = 10'($urandom_range(0, 1023));
            end
            #1;
            chk("ack_only_to_owning_host", host_ack && !(host_req && owner), 0);
            exp_we = host_ack ? host_we : (!cpu_hold && cpu_we);
            chk("ram_we_owner", ram_we, exp_we);
            chk("rvalid_timing", host_rvalid, prev_rd);
            if (host_rvalid && rd_q.size() > 0) chk("host_rdata", host_rdata, rd_q.pop_front());
            if (exp_crd_v && !(!cpu_hold && hold_prev)) chk("cpu_rdata", cpu_rdata, exp_crd);

            if (!cpu_hold && host_req) begin
                wait_cnt++;
                chk("host_wait_bound", wait_cnt <= CpuSlice + 1, 1);
            end
            if (cpu_hold && !hold_prev) begin
                if (have_grant) chk("cpu_slice_gap", gap >= CpuSlice, 1);
                gap = 0; wait_cnt = 0; grant_acks = 0;
            end
            if (!cpu_hold) begin
                gap++;
                if (hold_prev) have_grant = 1'b1;
            end
            if (host_ack) begin
                grant_acks++;
                chk("burst_limit", grant_acks <= MaxBurst, 1);
            end

            prev_rd = host_ack && !host_we;
            if (host_ack) begin
                if (host_we) ref_mem[host_addr] = host_wdata;
                else rd_q.push_back(ref_mem[host_addr]);
            end
            if (!cpu_hold) begin
                exp_crd_v = !cpu_we;
                exp_crd   = ref_mem[cpu_addr];
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            end
            ack_prev  = host_ack;
            hold_prev = cpu_hold;
        end
        host_req = 1'b0; cpu_we = 1'b0;
        repeat (3) @(negedge clk);
        compare_mem("mem_after_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
